// File: rtl/key_pkg.sv
// Shared definitions for the key debouncer: filter FSM encoding and the
// 50 MHz default timing constants also used by the LED stages.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILT_DN = 2'd1,
        DOWN    = 2'd2,
        FILT_UP = 2'd3
    } key_fsm_e;

    localparam int CNT_20MS_50M = 999999;
    localparam int CNT_1S_50M   = 49999999;

endpackage

// File: rtl/key_sync.sv
// Two-flop synchroniser plus one delay flop for the raw key; reports
// one-cycle fall/rise strobes of the synchronised level.
module key_sync (
    input  logic Clk,
    input  logic Reset,
    input  logic key_in,
    output logic key_fall,
    output logic key_rise
);

    logic s1, s2, s3;

    // All stages come out of reset as "released" so reset release cannot fake an edge.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= key_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign key_fall = s3 & ~s2;
    assign key_rise = ~s3 & s2;

endmodule

// File: rtl/key_filter.sv
// Push-key debouncer: clean press/release pulses and a debounced level.
// Define KEY_LONG_PRESS_EN to build the long-hold detector driving key_long.
module key_filter
    import key_pkg::*;
#(
    parameter int CNT_FILT = CNT_20MS_50M,
    parameter int CNT_LONG = CNT_1S_50M
) (
    input  logic Clk,
    input  logic Reset,
    input  logic key_in,
    output logic key_press,
    output logic key_release,
    output logic key_state,
    output logic key_long
);

    localparam int FW = $clog2(CNT_FILT + 1);

    if (CNT_FILT < 1 || CNT_LONG < 1) begin : g_bad_param
        $error("key_filter: CNT_FILT and CNT_LONG must be >= 1");
    end

    logic          key_fall, key_rise;
    key_fsm_e      state, state_nxt;
    logic [FW-1:0] cnt, cnt_nxt;
    logic          press_nxt, release_nxt;

    key_sync u_sync (
        .Clk      (Clk),
        .Reset    (Reset),
        .key_in   (key_in),
        .key_fall (key_fall),
        .key_rise (key_rise)
    );

    // A bounce edge takes priority over a completed window.
    always_comb begin
        state_nxt   = state;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        case (state)
            IDLE:    if (key_fall) state_nxt = FILT_DN;
            FILT_DN: begin
                if (key_rise) begin
                    state_nxt = IDLE;
                end else if (cnt == FW'(CNT_FILT)) begin
                    state_nxt = DOWN;
                    press_nxt = 1'b1;
                end
            end
            DOWN:    if (key_rise) state_nxt = FILT_UP;
            FILT_UP: begin
                if (key_fall) begin
                    state_nxt = DOWN;
                end else if (cnt == FW'(CNT_FILT)) begin
                    state_nxt   = IDLE;
                    release_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cnt_nxt = cnt;
        if (state_nxt != state)
            cnt_nxt = '0;
        else if (state == FILT_DN || state == FILT_UP)
            cnt_nxt = cnt + FW'(1);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            cnt         <= '0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_state   <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            key_press   <= press_nxt;
            key_release <= release_nxt;
            if (press_nxt)
                key_state <= 1'b1;
            else if (release_nxt)
                key_state <= 1'b0;
        end
    end

`ifdef KEY_LONG_PRESS_EN
    localparam int LW = $clog2(CNT_LONG + 1);

    logic [LW-1:0] long_cnt;
    logic          long_fired;
    logic          long_counting;
    logic          long_hit;

    assign long_counting = (state == DOWN) || (state == FILT_UP);
    assign long_hit      = long_counting && (long_cnt == LW'(CNT_LONG)) && !long_fired;

    // Restart only on a new press, so bounce during release cannot re-arm the pulse.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            long_cnt   <= '0;
            long_fired <= 1'b0;
            key_long   <= 1'b0;
        end else if (press_nxt) begin
            long_cnt   <= '0;
            long_fired <= 1'b0;
            key_long   <= 1'b0;
        end else begin
            key_long <= long_hit;
            if (long_hit)
                long_fired <= 1'b1;
            if (long_counting && long_cnt != LW'(CNT_LONG))
                long_cnt <= long_cnt + LW'(1);
        end
    end
`else
    assign key_long = 1'b0;
`endif

endmodule

// File: tb/tb_key_filter.sv
// Directed bench for key_filter with a run-length debounce model and
// hand-computed pulse timing (press/release 12 edges after the sample).
module tb_key_filter;
    import key_pkg::*;

    localparam int CNT_FILT = 9;
    localparam int CNT_LONG = 49;
    localparam int LAT      = CNT_FILT + 3;

    logic Clk = 1'b0;
    logic Reset;
    logic key_in;
    logic key_press, key_release, key_state, key_long;

    key_filter #(.CNT_FILT(CNT_FILT), .CNT_LONG(CNT_LONG)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .key_in      (key_in),
        .key_press   (key_press),
        .key_release (key_release),
        .key_state   (key_state),
        .key_long    (key_long)
    );

    // ---------------- clock / cycle counter ----------------
    always #10 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc = cyc + 1;

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_rel_q[$];
    logic [31:0] exp_long_q[$];

    task automatic chk(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The level flips once CNT_FILT+2 consecutive samples (seen two edges
    // late through the synchroniser) disagree with the current level.
    logic [1:0] dly;
    logic       seen;
    int         run, held;
    logic       m_level, m_press, m_release, m_long;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            dly = 2'b11; run = 0; held = 0;
            m_level = 1'b0; m_press = 1'b0; m_release = 1'b0; m_long = 1'b0;
        end else begin
            seen = dly[1];
            dly  = {dly[0], key_in};
            m_press = 1'b0; m_release = 1'b0; m_long = 1'b0;
            if (m_level) begin
                held++;
                if (held == CNT_LONG + 1) m_long = 1'b1;
            end
            if (~seen != m_level) run++;
            else run = 0;
            if (run == CNT_FILT + 2) begin
                run = 0;
                m_level = ~m_level;
                if (m_level) begin m_press = 1'b1; held = 0; end
                else m_release = 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge Clk) begin
        chk("key_press", key_press, m_press);
        chk("key_release", key_release, m_release);
        chk("key_state", key_state, m_level);
`ifdef KEY_LONG_PRESS_EN
        chk("key_long", key_long, m_long);
`else
        chk("key_long", key_long, 1'b0);
`endif
    end

    // ---------------- hand-computed pulse timing ----------------
    always @(negedge Clk) begin
        if (key_press === 1'b1) begin
            if (exp_q.size() == 0) chk_int("press_unexpected", cyc, -1);
            else chk_int("press_cycle", cyc, int'(exp_q.pop_front()));
        end
        if (key_release === 1'b1) begin
            if (exp_rel_q.size() == 0) chk_int("release_unexpected", cyc, -1);
            else chk_int("release_cycle", cyc, int'(exp_rel_q.pop_front()));
        end
        if (key_long === 1'b1) begin
            if (exp_long_q.size() == 0) chk_int("long_unexpected", cyc, -1);
            else chk_int("long_cycle", cyc, int'(exp_long_q.pop_front()));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_key(input logic v, input int n);
        key_in = v;
        repeat (n) @(negedge Clk);
    endtask

    // Steady press whose first low sample is the next edge (cyc+1).
    task automatic drive_press(input int n);
        exp_q.push_back(32'(cyc + 1 + LAT));
`ifdef KEY_LONG_PRESS_EN
        if (n >= CNT_LONG + 1) exp_long_q.push_back(32'(cyc + 1 + LAT + CNT_LONG + 1));
`endif
        drive_key(1'b0, n);
    endtask

    task automatic drive_release(input int n);
        exp_rel_q.push_back(32'(cyc + 1 + LAT));
        drive_key(1'b1, n);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        Reset  = 1'b1;
        key_in = 1'b1;
        repeat (3) @(negedge Clk);
        chk("reset_press", key_press, 1'b0);
        chk("reset_state", key_state, 1'b0);
        chk_int("reset_fsm", int'(dut.state), int'(IDLE));
        #2 Reset = 1'b0;
        drive_key(1'b1, 5);

        // clean press then release
        drive_press(100);
        chk("held_level", key_state, 1'b1);
        drive_release(40);
        chk("released_level", key_state, 1'b0);

        // bounce: 5 low, 3 high, then steady low
        drive_key(1'b0, 5);
        drive_key(1'b1, 3);
        drive_press(60);
        drive_release(40);

        // glitch of 8 cycles: rejected
        drive_key(1'b0, 8);
        drive_key(1'b1, 40);
        chk("glitch_level", key_state, 1'b0);
        chk_int("glitch_fsm", int'(dut.state), int'(IDLE));

        // window boundary: 10 low samples abort at cnt==CNT_FILT, 11 succeed
        drive_key(1'b0, 10);
        drive_key(1'b1, 40);
        drive_press(11);
        drive_release(40);

        // reset mid-filter (cnt=5 in FILT_DN), key kept low
        drive_key(1'b0, 8);
        #2 Reset = 1'b1;
        @(negedge Clk);
        chk("midrst_press", key_press, 1'b0);
        chk("midrst_state", key_state, 1'b0);
        @(negedge Clk);
        #2 Reset = 1'b0;
        drive_press(30);
        drive_release(40);

        // long hold
        drive_press(200);
        drive_release(40);

        repeat (5) @(negedge Clk);
        chk_int("press_q_left", exp_q.size(), 0);
        chk_int("release_q_left", exp_rel_q.size(), 0);
        chk_int("long_q_left", exp_long_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/key_filter.md
Name: key_filter

Overview:
- Debounces one raw active-low push key (50 MHz board clock) and emits clean one-cycle press/release pulses and a debounced level.
- Sits directly upstream of the LED flash stage and other LED stages. Its pulses drive rate/mode selection, or gate the flash counter's enable.
- Contains a 2-FF synchroniser, edge detector, 4-state filter FSM and filter counter.

Parameters:
CNT_FILT, 999999, filter window minus 1 in clock cycles (20 ms at 50 MHz); must be >= 1
CNT_LONG, 49999999, long-press hold time minus 1 in cycles (1 s); used only with the optional feature

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
key_in  input  1  raw key, asynchronous to Clk; 0 = pressed
key_press  output  1  one-cycle pulse on debounced press
key_release  output  1  one-cycle pulse on debounced release
key_state  output  1  debounced level; 1 = held
key_long  output  1  one-cycle pulse on long hold; tied 0 without the optional feature

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: key_press=0, key_release=0, key_state=0, key_long=0; FSM=IDLE; counters=0.
- Synchroniser flops s1, s2 and the delay flop s3 reset to 1 (released), so reset release never creates a false edge.
- Edges come from the synchronised signal: fall = s3 & ~s2, rise = ~s3 & s2.
- Filter counter width is $clog2(CNT_FILT+1) (20 bits by default).
- The counter clears on every state change and increments by 1 each cycle in FILT_DN/FILT_UP.
- FSM states and transitions:
  - IDLE: on fall -> FILT_DN.
  - FILT_DN: rise -> IDLE, no output (bounce rejected). Else cnt==CNT_FILT -> DOWN, key_press=1 for one cycle, key_state<=1. Else cnt++.
  - DOWN: on rise -> FILT_UP.
  - FILT_UP: fall -> DOWN, no output. Else cnt==CNT_FILT -> IDLE, key_release=1 for one cycle, key_state<=0. Else cnt++.
- Priority inside a filter state: a bounce edge in the same cycle as cnt==CNT_FILT wins; the window is restarted/aborted.
- Latency: if key_in is first sampled low at Clk edge k and stays stable, key_press goes high after edge k+CNT_FILT+3 and stays high for exactly one cycle. key_release has the same latency.
- key_state changes on the same edge as the corresponding pulse.
- Pulses are never back-to-back. At most one press per release.
- Key held through reset release: the resulting fall is filtered normally and a press is reported.
- Reset mid-filter: the window is abandoned and no pulse is emitted.
- Counter never wraps; it is bounded by CNT_FILT.

Optional Feature:
- KEY_LONG_PRESS_EN defined:
  - A long counter of width $clog2(CNT_LONG+1) clears on entry to DOWN and increments while in DOWN or FILT_UP.
  - It saturates at CNT_LONG.
  - When it reaches CNT_LONG, key_long pulses for one cycle, once per press.
  - Release before CNT_LONG gives no pulse.
- KEY_LONG_PRESS_EN undefined: no long counter is built; key_long is a constant 0. All other behaviour is identical.

Decomposition:
- Shared package key_pkg holds:
  - the state encoding IDLE=0, FILT_DN=1, DOWN=2, FILT_UP=3;
  - default constants CNT_20MS_50M=999999 and CNT_1S_50M=49999999, reused by the LED stages.
- One natural sub-module: key_sync (2-FF synchroniser, s3 delay, fall/rise outputs; reset to released).

Test Plan:
- Simulate with CNT_FILT=9, CNT_LONG=49.
- Clean press: key_in 1->0 sampled at edge k, held 100 cycles -> key_press high one cycle after edge k+12; key_state=1 from then.
- Bounce: key_in low 5 cycles, high 3, low steady -> no pulse during bounce; one key_press 12 edges after the final fall sample.
- Glitch: key_in low for 8 cycles then high -> no key_press; key_state stays 0; FSM back in IDLE.
- Release: from held, key_in 0->1 stable -> key_release one cycle, 12 edges after sample; key_state=0.
- Reset mid-filter: Reset pulse at cnt=5 in FILT_DN with key still low -> all outputs 0 during reset. After release, the fall is re-detected and key_press comes 12 edges after the first post-reset sample.
- KEY_LONG_PRESS_EN: hold 200 cycles -> exactly one key_long, 50 cycles after key_press; macro undefined -> key_long constantly 0.
